// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one ready/valid stream between N_INP requesters.
// A stalled beat stays granted (locked) until it handshakes, so the downstream
// never sees a withdrawn or swapped beat.
module stream_rr_arbiter #(
    parameter int unsigned N_INP      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W     = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic [N_INP-1:0][DATA_WIDTH-1:0] inp_data_i,
    input  logic [N_INP-1:0]                 inp_valid_i,
    output logic [N_INP-1:0]                 inp_ready_o,
    output logic [DATA_WIDTH-1:0]            oup_data_o,
    output logic                             oup_valid_o,
    input  logic                             oup_ready_i,
    output logic [IDX_W-1:0]                 oup_idx_o
);

    if (N_INP < 1) begin : g_n_inp_check
        $fatal(1, "stream_rr_arbiter: N_INP must be at least 1");
    end

    logic [IDX_W-1:0] rr_q;
    logic             lock_q;
    logic [IDX_W-1:0] lidx_q;

    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] granted;
    logic [IDX_W-1:0] rr_next;
    logic             handshake;

    // Pick the first valid requester at or after the priority pointer (cyclic)
    always_comb begin
        int unsigned best_off;
        int unsigned off;
        best_off = N_INP;
        off      = 0;
        scan_idx = rr_q;
        for (int unsigned i = 0; i < N_INP; i++) begin
            off = (i >= 32'(rr_q)) ? (i - 32'(rr_q)) : (i + N_INP - 32'(rr_q));
            if (inp_valid_i[i] && (off < best_off)) begin
                best_off = off;
                scan_idx = IDX_W'(i);
            end
        end
        granted = lock_q ? lidx_q : scan_idx;
    end

    // Output mux and one-hot upstream ready for the granted requester
    always_comb begin
        oup_valid_o = 1'b0;
        oup_data_o  = '0;
        for (int unsigned i = 0; i < N_INP; i++) begin
            if (IDX_W'(i) == granted) begin
                oup_valid_o = inp_valid_i[i];
                oup_data_o  = inp_data_i[i];
            end
        end
        oup_idx_o = granted;
        handshake = oup_valid_o && oup_ready_i;
        for (int unsigned i = 0; i < N_INP; i++) begin
            inp_ready_o[i] = handshake && (IDX_W'(i) == granted);
        end
    end

    // Pointer moves just past the served requester, wrapping at N_INP
    always_comb begin
        rr_next = (granted == IDX_W'(N_INP - 1)) ? '0 : (granted + IDX_W'(1));
    end

    // Arbitration state: flush beats handshake/stall updates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
        end else if (flush_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
        end else if (handshake) begin
            rr_q   <= rr_next;
            lock_q <= 1'b0;
        end else if (oup_valid_o) begin
            lock_q <= 1'b1;
            lidx_q <= granted;
        end else begin
            lock_q <= 1'b0;
        end
    end

    // Flags an upstream that withdraws a beat it has already offered
    assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> oup_valid_o)
        else $error("stream_rr_arbiter: locked requester dropped valid");

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios on N_INP = 1..4 instances
// plus a random-stall scoreboard soak on an N_INP = 5 instance.
module tb_stream_rr_arbiter;

    localparam int unsigned DW = 16;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_ni;
    logic flush_i;
    logic oup_ready_i;

    logic [0:0]          v1, r1;
    logic [0:0][DW-1:0]  d1;
    logic [DW-1:0]       od1;
    logic                ov1;
    logic [0:0]          oi1;

    logic [1:0]          v2, r2;
    logic [1:0][DW-1:0]  d2;
    logic [DW-1:0]       od2;
    logic                ov2;
    logic [0:0]          oi2;

    logic [2:0]          v3, r3;
    logic [2:0][DW-1:0]  d3;
    logic [DW-1:0]       od3;
    logic                ov3;
    logic [1:0]          oi3;

    logic [3:0]          v4, r4;
    logic [3:0][DW-1:0]  d4;
    logic [DW-1:0]       od4;
    logic                ov4;
    logic [1:0]          oi4;

    logic [4:0]          v5, r5;
    logic [4:0][DW-1:0]  d5;
    logic [DW-1:0]       od5;
    logic                ov5;
    logic [2:0]          oi5;

    stream_rr_arbiter #(.N_INP(1), .DATA_WIDTH(DW)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .inp_data_i(d1), .inp_valid_i(v1), .inp_ready_o(r1),
        .oup_data_o(od1), .oup_valid_o(ov1), .oup_ready_i(oup_ready_i), .oup_idx_o(oi1));
    stream_rr_arbiter #(.N_INP(2), .DATA_WIDTH(DW)) u_dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .inp_data_i(d2), .inp_valid_i(v2), .inp_ready_o(r2),
        .oup_data_o(od2), .oup_valid_o(ov2), .oup_ready_i(oup_ready_i), .oup_idx_o(oi2));
    stream_rr_arbiter #(.N_INP(3), .DATA_WIDTH(DW)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .inp_data_i(d3), .inp_valid_i(v3), .inp_ready_o(r3),
        .oup_data_o(od3), .oup_valid_o(ov3), .oup_ready_i(oup_ready_i), .oup_idx_o(oi3));
    stream_rr_arbiter #(.N_INP(4), .DATA_WIDTH(DW)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .inp_data_i(d4), .inp_valid_i(v4), .inp_ready_o(r4),
        .oup_data_o(od4), .oup_valid_o(ov4), .oup_ready_i(oup_ready_i), .oup_idx_o(oi4));
    stream_rr_arbiter #(.N_INP(5), .DATA_WIDTH(DW)) u_dut5 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .inp_data_i(d5), .inp_valid_i(v5), .inp_ready_o(r5),
        .oup_data_o(od5), .oup_valid_o(ov5), .oup_ready_i(oup_ready_i), .oup_idx_o(oi5));

    typedef struct {
        logic [7:0]    idx;
        logic          valid;
        logic [7:0]    rdy;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Soak scoreboard state
    logic [DW-1:0] exp5 [5][$];
    int            seq5  [5];
    int            wait5 [5];
    logic [4:0]    hs5;
    logic          stall5;
    logic [2:0]    pidx5;
    logic [DW-1:0] pdata5;
    int            served5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_valid(input int n, input logic [7:0] v);
        case (n)
            1: v1 = v[0:0];
            2: v2 = v[1:0];
            3: v3 = v[2:0];
            4: v4 = v[3:0];
            default: v5 = v[4:0];
        endcase
    endtask

    task automatic get_obs(input int n, output logic [7:0] idx, output logic val,
                           output logic [7:0] rdy, output logic [DW-1:0] data);
        case (n)
            1: begin idx = 8'(oi1); val = ov1; rdy = 8'(r1); data = od1; end
            2: begin idx = 8'(oi2); val = ov2; rdy = 8'(r2); data = od2; end
            3: begin idx = 8'(oi3); val = ov3; rdy = 8'(r3); data = od3; end
            4: begin idx = 8'(oi4); val = ov4; rdy = 8'(r4); data = od4; end
            default: begin idx = 8'(oi5); val = ov5; rdy = 8'(r5); data = od5; end
        endcase
    endtask

    // Directed payload of requester i on instance n is {n, i}
    task automatic push_exp(input int n, input int eidx, input logic ev, input logic rdy);
        exp_t e;
        e.idx   = 8'(eidx);
        e.valid = ev;
        e.rdy   = (rdy && ev) ? 8'(8'd1 << eidx) : 8'h00;
        e.data  = DW'((n << 12) | eidx);
        exp_q.push_back(e);
    endtask

    task automatic compare_out(input int n, input string tag);
        exp_t          e;
        logic [7:0]    idx;
        logic [7:0]    rdy;
        logic          val;
        logic [DW-1:0] data;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        get_obs(n, idx, val, rdy, data);
        check({tag, ".idx"},   32'(idx),  32'(e.idx));
        check({tag, ".valid"}, 32'(val),  32'(e.valid));
        check({tag, ".ready"}, 32'(rdy),  32'(e.rdy));
        check({tag, ".data"},  32'(data), 32'(e.data));
    endtask

    // One directed cycle: drive after the edge, compare mid-cycle
    task automatic cyc(input int n, input logic [7:0] v, input logic rdy, input logic fl,
                       input int eidx, input logic ev, input string tag);
        @(posedge clk_i); #1;
        set_valid(n, v);
        oup_ready_i = rdy;
        flush_i     = fl;
        push_exp(n, eidx, ev, rdy);
        @(negedge clk_i);
        compare_out(n, tag);
    endtask

    // One soak cycle: sources hold beats until accepted, scoreboard checks output
    task automatic soak_cycle(input bit drain);
        int            k;
        logic [DW-1:0] ev;
        @(posedge clk_i); #1;
        for (int i = 0; i < 5; i++) begin
            if (hs5[i]) v5[i] = 1'b0;
            if (!v5[i] && !drain && ($urandom_range(0, 99) < 55)) begin
                d5[i] = {4'(i), 12'(seq5[i])};
                seq5[i]++;
                exp5[i].push_back(d5[i]);
                wait5[i] = 0;
                v5[i] = 1'b1;
            end
        end
        oup_ready_i = drain ? 1'b1 : 1'($urandom_range(0, 99) < 65);
        @(negedge clk_i);
        if (stall5) begin
            check("soak.hold_idx",   32'(oi5), 32'(pidx5));
            check("soak.hold_data",  32'(od5), 32'(pdata5));
            check("soak.hold_valid", 32'(ov5), 32'd1);
        end
        hs5 = r5 & v5;
        if (ov5 && oup_ready_i) begin
            check("soak.ready", 32'(r5), 32'(5'(5'd1 << oi5)));
            check("soak.idx_range", 32'(oi5 < 3'd5), 32'd1);
            if (oi5 < 3'd5) begin
                k = int'(oi5);
                check("soak.not_empty", 32'(exp5[k].size() != 0), 32'd1);
                if (exp5[k].size() != 0) begin
                    ev = exp5[k].pop_front();
                    check("soak.data", 32'(od5), 32'(ev));
                end
                check("soak.fair", 32'(wait5[k] < 5), 32'd1);
                for (int i = 0; i < 5; i++) begin
                    if (v5[i] && (i != k)) wait5[i]++;
                end
                served5++;
            end
        end else begin
            check("soak.no_ready", 32'(r5), 32'd0);
        end
        stall5 = ov5 && !oup_ready_i;
        pidx5  = oi5;
        pdata5 = od5;
    endtask

    initial begin
        int left;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        oup_ready_i = 1'b0;
        v1 = '0; v2 = '0; v3 = '0; v4 = '0; v5 = '0;
        d5 = '0;
        for (int i = 0; i < 1; i++) d1[i] = DW'((1 << 12) | i);
        for (int i = 0; i < 2; i++) d2[i] = DW'((2 << 12) | i);
        for (int i = 0; i < 3; i++) d3[i] = DW'((3 << 12) | i);
        for (int i = 0; i < 4; i++) d4[i] = DW'((4 << 12) | i);
        for (int i = 0; i < 5; i++) begin
            seq5[i]  = 0;
            wait5[i] = 0;
        end
        hs5     = '0;
        stall5  = 1'b0;
        pidx5   = '0;
        pdata5  = '0;
        served5 = 0;

        // Reset state: idle, index 0, no ready
        @(negedge clk_i);
        for (int n = 1; n <= 4; n++) begin
            push_exp(n, 0, 1'b0, 1'b0);
            compare_out(n, "reset");
        end
        @(posedge clk_i); #2;
        rst_ni = 1'b1;

        // N_INP=2: alternating grants with both valid and ready high
        for (int k = 0; k < 5; k++) cyc(2, 8'b11, 1'b1, 1'b0, k % 2, 1'b1, "t1.rr");

        // N_INP=2 lock-in: req0 stalled, req1 arrives, pointer favours req1
        cyc(2, 8'b01, 1'b0, 1'b0, 0, 1'b1, "t2.stall0");
        cyc(2, 8'b11, 1'b0, 1'b0, 0, 1'b1, "t2.stall1");
        cyc(2, 8'b11, 1'b0, 1'b0, 0, 1'b1, "t2.stall2");
        cyc(2, 8'b11, 1'b1, 1'b0, 0, 1'b1, "t2.hs0");
        cyc(2, 8'b11, 1'b1, 1'b0, 1, 1'b1, "t2.next");
        cyc(2, 8'b00, 1'b0, 1'b0, 0, 1'b0, "t2.idle");

        // N_INP=3: wrap-around at 3, never index 3
        cyc(3, 8'b010, 1'b1, 1'b0, 1, 1'b1, "t3.req1");
        cyc(3, 8'b001, 1'b1, 1'b0, 0, 1'b1, "t3.wrap0");
        cyc(3, 8'b111, 1'b1, 1'b0, 1, 1'b1, "t3.ptr1");
        cyc(3, 8'b111, 1'b1, 1'b0, 2, 1'b1, "t3.ptr2");
        cyc(3, 8'b111, 1'b1, 1'b0, 0, 1'b1, "t3.wrap");
        cyc(3, 8'b000, 1'b1, 1'b0, 1, 1'b0, "t3.idle");

        // N_INP=4: flush while req2 is locked
        cyc(4, 8'b0100, 1'b0, 1'b0, 2, 1'b1, "t4.lock2");
        cyc(4, 8'b0101, 1'b0, 1'b1, 2, 1'b1, "t4.flush");
        cyc(4, 8'b0101, 1'b0, 1'b0, 0, 1'b1, "t4.after");
        cyc(4, 8'b0101, 1'b1, 1'b0, 0, 1'b1, "t4.hs0");
        cyc(4, 8'b0101, 1'b1, 1'b0, 2, 1'b1, "t4.hs2");
        cyc(4, 8'b0000, 1'b0, 1'b0, 3, 1'b0, "t4.idle");

        // N_INP=4: async reset in the middle of a stall on req3
        cyc(4, 8'b1010, 1'b1, 1'b0, 3, 1'b1, "t5.hs3");
        cyc(4, 8'b1010, 1'b1, 1'b0, 1, 1'b1, "t5.hs1");
        cyc(4, 8'b1010, 1'b0, 1'b0, 3, 1'b1, "t5.stall3");
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        push_exp(4, 1, 1'b1, 1'b0);
        compare_out(4, "t5.in_reset");
        @(posedge clk_i); #2;
        rst_ni = 1'b1;
        cyc(4, 8'b1010, 1'b1, 1'b0, 1, 1'b1, "t5.after");
        cyc(4, 8'b1010, 1'b1, 1'b0, 3, 1'b1, "t5.next");
        cyc(4, 8'b0000, 1'b0, 1'b0, 0, 1'b0, "t5.idle");

        // N_INP=1: passthrough
        cyc(1, 8'b1, 1'b0, 1'b0, 0, 1'b1, "n1.stall");
        cyc(1, 8'b1, 1'b1, 1'b0, 0, 1'b1, "n1.hs");
        cyc(1, 8'b0, 1'b1, 1'b0, 0, 1'b0, "n1.idle");

        // N_INP=5 random-stall soak, then drain
        for (int c = 0; c < 2000; c++) soak_cycle(1'b0);
        for (int c = 0; c < 40; c++) soak_cycle(1'b1);
        left = 0;
        for (int i = 0; i < 5; i++) left += exp5[i].size();
        check("soak.drained", 32'(left), 32'd0);
        check("soak.activity", 32'(served5 > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
